sd_init_sequencer: RTL and testbench
====================================

Name: sd_init_sequencer

Overview:
- Parametrised SPI-mode SD card initialisation sequencer; successor to the fixed CMD0/CMD8 initializer.
- Drives the full power-up flow: power-up clocks, CMD0, CMD8, CMD55/ACMD41 loop, CMD58.
- Adds bounded retries, response timeouts, v1/v2 card detection, SDHC (CCS) capture and error reporting.
- Sits between the SD controller top and the SPI byte engine; it owns SDCS until `initialized` is set.

Parameters:
POWERUP_BYTES, 10, number of 0xFF bytes sent with SDCS high before CMD0 (10 bytes = 80 SCLKs)
RESP_TIMEOUT, 8, max 0xFF poll bytes while waiting for an R1 start (bit7=0) before timeout
CMD0_RETRIES, 4, CMD0 attempts before error
ACMD41_RETRIES, 1000, CMD55+ACMD41 pairs before error

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins sequence; ignored while busy
byte_done  in  1  SPI engine pulse; current tx_byte shifted out, rx_byte valid this cycle
rx_byte  in  8  byte received during the transfer just completed
tx_byte  out  8  byte to shift out next
tx_valid  out  1  request to the SPI engine to transfer tx_byte
spi_enable  out  1  SPI engine enable, high from start until DONE/ERROR
SDCS  out  1  card chip select, active low
busy  out  1  sequence in progress
initialized  out  1  sticky; card ready
init_error  out  1  sticky; sequence aborted
error_code  out  3  0 none, 1 CMD0 fail, 2 CMD8 echo/pattern bad, 3 ACMD41 retries exhausted, 4 R1 timeout, 5 unexpected R1
is_sdhc  out  1  OCR CCS bit (valid when initialized)
card_v2  out  1  card answered CMD8 legally

Behaviour:
- Clock `clk`; reset `n_rst` is asynchronous, active-low.
- Reset values: tx_byte=0xFF, tx_valid=0, spi_enable=0, SDCS=1, busy=0, initialized=0, init_error=0, error_code=0, is_sdhc=0, card_v2=0. Reset mid-sequence aborts immediately to IDLE.
- Handshake: while tx_valid=1, tx_byte is held stable until byte_done. On the byte_done cycle the FSM samples rx_byte and registers the next tx_byte/state, which are visible the following cycle. byte_done while tx_valid=0 is ignored.
- States: IDLE, POWERUP, SEND_CMD, WAIT_R1, READ_TAIL, GAP, DONE, ERROR.
- IDLE: on start, clear flags, go to POWERUP; spi_enable=1, busy=1.
- POWERUP: SDCS=1; send POWERUP_BYTES of 0xFF, then SDCS=0 and load CMD0.
- SEND_CMD: 6 bytes: {0x40|idx}, arg[31:24..7:0], crc byte.
  - CMD0: arg 0, crc 0x95.
  - CMD8: arg 0x000001AA, crc 0x87.
  - CMD55: arg 0, crc 0x65.
  - ACMD41: arg 0x40000000 if card_v2, else 0; crc 0x77.
  - CMD58: arg 0, crc 0xFD.
  - After byte 6, go to WAIT_R1.
- WAIT_R1: send 0xFF. rx_byte[7]=0 latches R1. If RESP_TIMEOUT bytes pass with no R1 start, then error 4; for CMD0 a timeout consumes one retry instead.
- Response evaluation, after latching R1:
  - CMD0: R1==0x01 → CMD8. Otherwise retry while attempts<CMD0_RETRIES; else error 1.
  - CMD8: R1==0x01 → READ_TAIL 4 bytes; require tail[2][3:0]==1 and tail[3]==0xAA, then card_v2=1 → CMD55; else error 2. R1 with bit2 set (e.g. 0x05) → card_v2=0, no tail, → CMD55. Any other R1 → error 5.
  - CMD55: R1 of 0x00 or 0x01 → ACMD41; else error 5.
  - ACMD41: R1==0x00 → CMD58 if card_v2, else DONE with is_sdhc=0. R1==0x01 → increment loop counter; if below ACMD41_RETRIES → CMD55, else error 3. Other R1 → error 5.
  - CMD58: R1==0x00 → READ_TAIL 4 bytes, is_sdhc=tail[0][6] → DONE; else error 5.
- GAP: one 0xFF byte with SDCS low after each complete response (and tail) before the next SEND_CMD.
- DONE: initialized=1, busy=0, tx_valid=0, spi_enable=0, SDCS=0.
- ERROR: init_error=1, error_code set, SDCS=1, tx_valid=0, spi_enable=0, busy=0.
- start from DONE/ERROR restarts the full sequence and clears flags.
- Counter widths: $clog2(param+1). Retry and loop counters saturate and never wrap.

Test Plan:
- v2 SDHC card: model returns CMD0→0x01, CMD8→0x01 tail 00 00 01 AA, ACMD41→0x01 twice then 0x00, CMD58→0x00 tail C0 FF 80 00 → initialized=1, is_sdhc=1, card_v2=1, exactly 10 power-up bytes with SDCS=1, 3 CMD55/ACMD41 pairs.
- v1 card: CMD8 R1=0x05 → no tail read, ACMD41 arg 0, DONE after ACMD41 0x00 with no CMD58, is_sdhc=0, card_v2=0.
- Card never answers (rx=0xFF always) → 4 CMD0 attempts, each with 8 poll bytes, then init_error=1, error_code=1.
- CMD8 tail 00 00 01 55 → error_code=2; ACMD41 always 0x01 with ACMD41_RETRIES=5 → error_code=3 after 5 pairs.
- Timeout: CMD8 response all 0xFF → error_code=4 after RESP_TIMEOUT poll bytes; SDCS returns high.
- Assert n_rst mid-CMD8 frame → all outputs at reset values asynchronously; a new start performs a clean full sequence. Also check start while busy is ignored, and that tx_byte holds stable across 3-cycle gaps between byte_done pulses.

Source files
------------

// File: rtl/sd_init_sequencer_if.sv
// Byte-level handshake between the SD init sequencer and the SPI byte engine.
interface sd_init_sequencer_if;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       spi_enable;
    logic       byte_done;
    logic [7:0] rx_byte;

    modport master (output tx_byte, tx_valid, spi_enable, input byte_done, rx_byte);
    modport slave  (input tx_byte, tx_valid, spi_enable, output byte_done, rx_byte);
endinterface

// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card power-up sequencer: CMD0, CMD8, CMD55/ACMD41 loop, CMD58,
// with retries, R1 timeouts, v1/v2 detection and SDHC capture.
module sd_init_sequencer #(
    parameter int POWERUP_BYTES  = 10,
    parameter int RESP_TIMEOUT   = 8,
    parameter int CMD0_RETRIES   = 4,
    parameter int ACMD41_RETRIES = 1000
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       start,
    sd_init_sequencer_if.master        spi,
    output logic                       SDCS,
    output logic                       busy,
    output logic                       initialized,
    output logic                       init_error,
    output logic [2:0]                 error_code,
    output logic                       is_sdhc,
    output logic                       card_v2
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_POWERUP   = 3'd1;
    localparam logic [2:0] S_SEND_CMD  = 3'd2;
    localparam logic [2:0] S_WAIT_R1   = 3'd3;
    localparam logic [2:0] S_READ_TAIL = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_ERROR     = 3'd7;

    localparam logic [2:0] C_CMD0   = 3'd0;
    localparam logic [2:0] C_CMD8   = 3'd1;
    localparam logic [2:0] C_CMD55  = 3'd2;
    localparam logic [2:0] C_ACMD41 = 3'd3;
    localparam logic [2:0] C_CMD58  = 3'd4;

    localparam logic [2:0] E_NONE   = 3'd0;
    localparam logic [2:0] E_CMD0   = 3'd1;
    localparam logic [2:0] E_CMD8   = 3'd2;
    localparam logic [2:0] E_ACMD41 = 3'd3;
    localparam logic [2:0] E_TMO    = 3'd4;
    localparam logic [2:0] E_R1     = 3'd5;

    // byte_cnt covers power-up bytes, poll bytes and the 6-byte frame
    localparam int CNT_MAX0 = (POWERUP_BYTES > RESP_TIMEOUT) ? POWERUP_BYTES : RESP_TIMEOUT;
    localparam int CNT_MAX  = (CNT_MAX0 > 6) ? CNT_MAX0 : 6;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int C0_W     = $clog2(CMD0_RETRIES + 1);
    localparam int A41_W    = $clog2(ACMD41_RETRIES + 1);

    logic [2:0]       state;
    logic [2:0]       cmd;
    logic [CNT_W-1:0] byte_cnt;
    logic [C0_W-1:0]  cmd0_cnt;
    logic [A41_W-1:0] acmd_cnt;
    logic [7:0]       tx_byte_q;
    logic             tail0_b6;
    logic [3:0]       tail2_lo;
    logic             active;

    // Byte idx (0..5) of the command frame for command c
    function automatic logic [7:0] cmd_byte(input logic [2:0] c, input logic [2:0] idx,
                                            input logic v2);
        logic [5:0]  ci;
        logic [31:0] arg;
        logic [7:0]  crc;
        logic [7:0]  b;
        case (c)
            C_CMD8:   begin ci = 6'd8;  arg = 32'h0000_01AA; crc = 8'h87; end
            C_CMD55:  begin ci = 6'd55; arg = 32'h0;         crc = 8'h65; end
            C_ACMD41: begin ci = 6'd41; arg = v2 ? 32'h4000_0000 : 32'h0; crc = 8'h77; end
            C_CMD58:  begin ci = 6'd58; arg = 32'h0;         crc = 8'hFD; end
            default:  begin ci = 6'd0;  arg = 32'h0;         crc = 8'h95; end
        endcase
        case (idx)
            3'd0:    b = {2'b01, ci};
            3'd1:    b = arg[31:24];
            3'd2:    b = arg[23:16];
            3'd3:    b = arg[15:8];
            3'd4:    b = arg[7:0];
            default: b = crc;
        endcase
        return b;
    endfunction

    // Outcome of a WAIT_R1 step that ends polling (R1 seen, or timeout with rx=0xFF)
    logic [2:0] ev_state, ev_cmd, ev_err;
    logic       ev_cmd0_inc, ev_acmd_inc;
    logic       cmd0_bad;

    assign cmd0_bad = (cmd == C_CMD0) && (spi.rx_byte != 8'h01);

    always_comb begin
        ev_state    = S_GAP;
        ev_cmd      = cmd;
        ev_err      = E_NONE;
        ev_cmd0_inc = 1'b0;
        ev_acmd_inc = 1'b0;
        if (cmd0_bad) begin
            if (cmd0_cnt < C0_W'(CMD0_RETRIES - 1)) begin
                ev_cmd0_inc = 1'b1;
                ev_cmd      = C_CMD0;
            end else begin
                ev_state = S_ERROR;
                ev_err   = E_CMD0;
            end
        end else if (spi.rx_byte[7]) begin
            ev_state = S_ERROR;
            ev_err   = E_TMO;
        end else begin
            case (cmd)
                C_CMD0: ev_cmd = C_CMD8;
                C_CMD8: begin
                    if (spi.rx_byte == 8'h01)   ev_state = S_READ_TAIL;
                    else if (spi.rx_byte[2])    ev_cmd   = C_CMD55;
                    else begin ev_state = S_ERROR; ev_err = E_R1; end
                end
                C_CMD55: begin
                    if (spi.rx_byte[7:1] == 7'd0) ev_cmd = C_ACMD41;
                    else begin ev_state = S_ERROR; ev_err = E_R1; end
                end
                C_ACMD41: begin
                    if (spi.rx_byte == 8'h00) begin
                        if (card_v2) ev_cmd   = C_CMD58;
                        else         ev_state = S_DONE;
                    end else if (spi.rx_byte == 8'h01) begin
                        if (acmd_cnt < A41_W'(ACMD41_RETRIES - 1)) begin
                            ev_acmd_inc = 1'b1;
                            ev_cmd      = C_CMD55;
                        end else begin
                            ev_state = S_ERROR;
                            ev_err   = E_ACMD41;
                        end
                    end else begin
                        ev_state = S_ERROR;
                        ev_err   = E_R1;
                    end
                end
                C_CMD58: begin
                    if (spi.rx_byte == 8'h00) ev_state = S_READ_TAIL;
                    else begin ev_state = S_ERROR; ev_err = E_R1; end
                end
                default: begin ev_state = S_ERROR; ev_err = E_R1; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            cmd         <= C_CMD0;
            byte_cnt    <= '0;
            cmd0_cnt    <= '0;
            acmd_cnt    <= '0;
            tx_byte_q   <= 8'hFF;
            SDCS        <= 1'b1;
            initialized <= 1'b0;
            init_error  <= 1'b0;
            error_code  <= E_NONE;
            is_sdhc     <= 1'b0;
            card_v2     <= 1'b0;
            tail0_b6    <= 1'b0;
            tail2_lo    <= 4'd0;
        end else begin
            case (state)
                S_POWERUP: if (spi.byte_done) begin
                    if (byte_cnt == CNT_W'(POWERUP_BYTES - 1)) begin
                        state     <= S_SEND_CMD;
                        SDCS      <= 1'b0;
                        byte_cnt  <= '0;
                        tx_byte_q <= cmd_byte(C_CMD0, 3'd0, 1'b0);
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                S_SEND_CMD: if (spi.byte_done) begin
                    if (byte_cnt == CNT_W'(5)) begin
                        state     <= S_WAIT_R1;
                        byte_cnt  <= '0;
                        tx_byte_q <= 8'hFF;
                    end else begin
                        byte_cnt  <= byte_cnt + 1'b1;
                        tx_byte_q <= cmd_byte(cmd, 3'(byte_cnt + 1'b1), card_v2);
                    end
                end
                S_WAIT_R1: if (spi.byte_done) begin
                    if (!spi.rx_byte[7] || byte_cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
                        state    <= ev_state;
                        cmd      <= ev_cmd;
                        byte_cnt <= '0;
                        if (ev_cmd0_inc) cmd0_cnt <= cmd0_cnt + 1'b1;
                        if (ev_acmd_inc) acmd_cnt <= acmd_cnt + 1'b1;
                        if (ev_state == S_DONE) initialized <= 1'b1;
                        if (ev_state == S_ERROR) begin
                            init_error <= 1'b1;
                            error_code <= ev_err;
                            SDCS       <= 1'b1;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                S_READ_TAIL: if (spi.byte_done) begin
                    if (byte_cnt == CNT_W'(0)) tail0_b6 <= spi.rx_byte[6];
                    if (byte_cnt == CNT_W'(2)) tail2_lo <= spi.rx_byte[3:0];
                    if (byte_cnt == CNT_W'(3)) begin
                        byte_cnt <= '0;
                        if (cmd == C_CMD8) begin
                            if (tail2_lo == 4'h1 && spi.rx_byte == 8'hAA) begin
                                card_v2 <= 1'b1;
                                cmd     <= C_CMD55;
                                state   <= S_GAP;
                            end else begin
                                state      <= S_ERROR;
                                init_error <= 1'b1;
                                error_code <= E_CMD8;
                                SDCS       <= 1'b1;
                            end
                        end else begin
                            is_sdhc     <= tail0_b6;
                            initialized <= 1'b1;
                            state       <= S_DONE;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                S_GAP: if (spi.byte_done) begin
                    state     <= S_SEND_CMD;
                    byte_cnt  <= '0;
                    tx_byte_q <= cmd_byte(cmd, 3'd0, card_v2);
                end
                default: if (start) begin
                    // IDLE, DONE and ERROR all restart the whole sequence
                    state       <= S_POWERUP;
                    cmd         <= C_CMD0;
                    byte_cnt    <= '0;
                    cmd0_cnt    <= '0;
                    acmd_cnt    <= '0;
                    tx_byte_q   <= 8'hFF;
                    SDCS        <= 1'b1;
                    initialized <= 1'b0;
                    init_error  <= 1'b0;
                    error_code  <= E_NONE;
                    is_sdhc     <= 1'b0;
                    card_v2     <= 1'b0;
                end
            endcase
        end
    end

    assign active         = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
    assign busy           = active;
    assign spi.tx_valid   = active;
    assign spi.spi_enable = active;
    assign spi.tx_byte    = tx_byte_q;
endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench: SPI engine + SD card response model around sd_init_sequencer.
module tb_sd_init_sequencer;
    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic       SDCS, busy, initialized, init_error, is_sdhc, card_v2;
    logic [2:0] error_code;

    sd_init_sequencer_if sif ();

    sd_init_sequencer #(.ACMD41_RETRIES(5)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .spi(sif), .SDCS(SDCS), .busy(busy),
        .initialized(initialized), .init_error(init_error), .error_code(error_code),
        .is_sdhc(is_sdhc), .card_v2(card_v2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    localparam logic [18:0] RST_VEC = {8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

    function automatic logic [18:0] outs();
        return {sif.tx_byte, sif.tx_valid, sif.spi_enable, SDCS, busy, initialized, init_error,
                error_code, is_sdhc, card_v2};
    endfunction

    // card model state
    logic [7:0]  rq[$];
    logic [7:0]  fb[6];
    int          fpos, pu_bytes, low_ff, frame_err, stab_err;
    int          n_cmd0, n_cmd8, n_cmd55, n_acmd41, n_cmd58;
    int          silent, acmd_ones, eng_gap;
    logic [7:0]  cmd8_r1;
    logic [31:0] cmd8_tail, cmd58_tail, acmd41_arg;

    task automatic push_word(input logic [31:0] w);
        rq.push_back(w[31:24]); rq.push_back(w[23:16]);
        rq.push_back(w[15:8]);  rq.push_back(w[7:0]);
    endtask

    task automatic frame_end();
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [7:0]  crc;
        idx = fb[0][5:0];
        arg = {fb[1], fb[2], fb[3], fb[4]};
        case (idx)
            6'd0:  begin crc = 8'h95; n_cmd0++;
                         if (arg != 0) frame_err++;
                         if (silent != 0) rq.push_back(8'h01); end
            6'd8:  begin crc = 8'h87; n_cmd8++;
                         if (arg != 32'h1AA) frame_err++;
                         if (silent != 8) begin
                             rq.push_back(cmd8_r1);
                             if (cmd8_r1 == 8'h01) push_word(cmd8_tail);
                         end end
            6'd55: begin crc = 8'h65; n_cmd55++;
                         if (arg != 0) frame_err++;
                         rq.push_back(8'h01); end
            6'd41: begin crc = 8'h77; n_acmd41++; acmd41_arg = arg;
                         rq.push_back((acmd_ones < 0 || n_acmd41 <= acmd_ones) ? 8'h01 : 8'h00); end
            6'd58: begin crc = 8'hFD; n_cmd58++;
                         if (arg != 0) frame_err++;
                         rq.push_back(8'h00); push_word(cmd58_tail); end
            default: begin crc = 8'h00; frame_err++; end
        endcase
        if (fb[5] != crc) frame_err++;
    endtask

    task automatic card_xfer(input logic [7:0] tx, input logic cs, output logic [7:0] rx);
        rx = 8'hFF;
        if (cs) begin
            if (tx == 8'hFF) pu_bytes++;
        end else if (fpos > 0) begin
            fb[fpos] = tx;
            fpos++;
            if (fpos == 6) begin fpos = 0; frame_end(); end
        end else if (tx[7:6] == 2'b01) begin
            fb[0] = tx;
            fpos  = 1;
        end else begin
            low_ff++;
            if (rq.size() > 0) rx = rq.pop_front();
        end
    endtask

    // SPI engine: completes each byte eng_gap cycles after it is presented
    initial begin
        logic [7:0] held, r;
        int         wcnt;
        bit         pending;
        pending = 0; wcnt = 0; held = 8'hFF;
        sif.byte_done = 1'b0;
        sif.rx_byte   = 8'hFF;
        forever begin
            @(negedge clk);
            sif.byte_done = 1'b0;
            if (!n_rst) begin
                pending = 0;
                continue;
            end
            if (sif.tx_valid && !pending) begin
                pending = 1; held = sif.tx_byte; wcnt = 0;
            end
            if (pending) begin
                if (sif.tx_byte !== held) stab_err++;
                wcnt++;
                if (wcnt >= eng_gap) begin
                    card_xfer(sif.tx_byte, SDCS, r);
                    sif.rx_byte   = r;
                    sif.byte_done = 1'b1;
                    pending       = 0;
                end
            end
        end
    end

    task automatic setup(input int sil, input logic [7:0] r8, input logic [31:0] t8,
                         input int ones, input int gap);
        rq.delete();
        fpos = 0; pu_bytes = 0; low_ff = 0; frame_err = 0; stab_err = 0;
        n_cmd0 = 0; n_cmd8 = 0; n_cmd55 = 0; n_acmd41 = 0; n_cmd58 = 0;
        silent = sil; cmd8_r1 = r8; cmd8_tail = t8; acmd_ones = ones; eng_gap = gap;
        cmd58_tail = 32'hC0FF_8000; acmd41_arg = 32'hDEAD_BEEF;
    endtask

    task automatic kick(input string tag);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, "_busy"}, {busy, sif.spi_enable, sif.tx_valid, SDCS}, 4'b1111);
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy && i < 20000) begin @(negedge clk); i++; end
        chk({tag, "_end"}, busy, 1'b0);
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0;
        setup(-1, 8'h01, 32'h0000_01AA, 2, 1);
        repeat (3) @(negedge clk);
        chk("reset_vals", outs(), RST_VEC);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_vals", outs(), RST_VEC);

        // v2 SDHC, slow engine, stray start mid-sequence
        setup(-1, 8'h01, 32'h0000_01AA, 2, 4);
        kick("v2");
        repeat (30) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_idle("v2");
        chk("v2_flags", {initialized, init_error, error_code, is_sdhc, card_v2}, 7'b1000011);
        chk("v2_pins", {SDCS, sif.tx_valid, sif.spi_enable}, 3'b000);
        chk("v2_pu", pu_bytes, 10);
        chk("v2_pairs", {n_cmd55[7:0], n_acmd41[7:0]}, 16'h0303);
        chk("v2_c58", n_cmd58, 1);
        chk("v2_arg", acmd41_arg, 32'h4000_0000);
        chk("v2_ff", low_ff, 25);
        chk("v2_frm", frame_err, 0);
        chk("v2_stable", stab_err, 0);

        // v1 card
        setup(-1, 8'h05, 32'h0, 0, 1);
        kick("v1");
        wait_idle("v1");
        chk("v1_flags", {initialized, init_error, error_code, is_sdhc, card_v2}, 7'b1000000);
        chk("v1_c58", n_cmd58, 0);
        chk("v1_arg", acmd41_arg, 32'h0);
        chk("v1_ff", low_ff, 7);
        chk("v1_frm", frame_err, 0);

        // silent card: 4 CMD0 attempts x 8 polls plus 3 gap bytes
        setup(0, 8'h01, 32'h0000_01AA, 0, 1);
        kick("nocard");
        wait_idle("nocard");
        chk("nocard_err", {initialized, init_error, error_code, SDCS}, 6'b010011);
        chk("nocard_c0", n_cmd0, 4);
        chk("nocard_ff", low_ff, 35);
        chk("nocard_c8", n_cmd8, 0);

        // bad CMD8 check pattern
        setup(-1, 8'h01, 32'h0000_0155, 0, 1);
        kick("badpat");
        wait_idle("badpat");
        chk("badpat_err", {init_error, error_code, card_v2, SDCS}, 6'b101001);

        // ACMD41 never leaves idle
        setup(-1, 8'h01, 32'h0000_01AA, -1, 1);
        kick("a41");
        wait_idle("a41");
        chk("a41_err", {init_error, error_code, initialized}, 5'b10110);
        chk("a41_pairs", {n_cmd55[7:0], n_acmd41[7:0]}, 16'h0505);

        // CMD8 response timeout
        setup(8, 8'h01, 32'h0000_01AA, 0, 1);
        kick("tmo");
        wait_idle("tmo");
        chk("tmo_err", {init_error, error_code, SDCS, sif.spi_enable}, 6'b110010);
        chk("tmo_ff", low_ff, 10);

        // async reset in the middle of the CMD8 frame, then a clean restart
        setup(-1, 8'h01, 32'h0000_01AA, 2, 1);
        kick("rst");
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (fpos >= 2 && fb[0] == 8'h48) break;
        end
        chk("rst_in_cmd8", {fb[0], busy}, {8'h48, 1'b1});
        #2 n_rst = 1'b0;
        #1 chk("rst_async", outs(), RST_VEC);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        setup(-1, 8'h01, 32'h0000_01AA, 2, 1);
        kick("rerun");
        wait_idle("rerun");
        chk("rerun_flags", {initialized, init_error, error_code, is_sdhc, card_v2}, 7'b1000011);
        chk("rerun_pu", pu_bytes, 10);
        chk("rerun_frm", frame_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
